// File: rtl/i2c_sel_target.sv
// I2C target that sets a 3-bit fan-out channel select from written bytes
// and returns {5'b0, sel} on reads.
// Ports: clk, rst (sync, active-high), scl_in/sda_in (async bus levels),
//        sda_oe (1 = pull SDA low), sel/sel_valid (select + update pulse),
//        busy (START seen, STOP not yet seen).
module i2c_sel_target #(
  parameter logic [6:0] ADDR = 7'h70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [2:0] sel,
  output logic       sel_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  state_t      state_q, state_d;
  // [0],[1] synchronizer stages, [2] history for edge detection
  logic [2:0]  scl_q, scl_d;
  logic [2:0]  sda_q, sda_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic        sda_oe_q, sda_oe_d;
  logic [2:0]  sel_q, sel_d;
  logic        sel_valid_q, sel_valid_d;
  logic        busy_q, busy_d;

  logic       scl_s, scl_h, sda_s, sda_h;
  logic       scl_rise, scl_fall, start, stop;
  logic       last_bit;
  logic [7:0] byte_in;
  logic [7:0] rd_byte;

  always_comb begin
    scl_d    = {scl_q[1:0], scl_in};
    sda_d    = {sda_q[1:0], sda_in};
    scl_s    = scl_q[1];
    scl_h    = scl_q[2];
    sda_s    = sda_q[1];
    sda_h    = sda_q[2];
    scl_rise = scl_s & ~scl_h;
    scl_fall = ~scl_s & scl_h;
    start    = scl_s & scl_h & sda_h & ~sda_s;
    stop     = scl_s & scl_h & ~sda_h & sda_s;
    byte_in  = {shift_q, sda_s};
    rd_byte  = {5'b0, sel_q};
    last_bit = (cnt_q == 3'd7);

    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    sda_oe_d    = sda_oe_q;
    sel_d       = sel_q;
    sel_valid_d = 1'b0;
    busy_d      = busy_q;

    if (start) begin
      state_d  = S_ADDR;
      cnt_d    = 3'd0;
      shift_d  = 7'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ADDR: if (scl_rise) begin
          shift_d = byte_in[6:0];
          cnt_d   = cnt_q + 3'd1;
          if (last_bit)
            state_d = (byte_in[7:1] == ADDR) ? S_ADDR_ACK : S_IGNORE;
        end
        // first fall drives ACK, second fall ends the slot
        S_ADDR_ACK: if (scl_fall) begin
          cnt_d = 3'd0;
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (shift_q[0]) begin
            state_d  = S_RD_DATA;
            tx_d     = rd_byte;
            sda_oe_d = ~rd_byte[7];
          end else begin
            state_d  = S_WR_DATA;
            sda_oe_d = 1'b0;
          end
        end
        S_WR_DATA: if (scl_rise) begin
          shift_d = byte_in[6:0];
          cnt_d   = cnt_q + 3'd1;
          if (last_bit) begin
            if (byte_in[7:3] == 5'd0) begin
              sel_d       = byte_in[2:0];
              sel_valid_d = 1'b1;
              state_d     = S_WR_ACK;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_WR_ACK: if (scl_fall) begin
          cnt_d = 3'd0;
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          if (scl_fall)
            sda_oe_d = ~tx_q[~cnt_q];
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (last_bit)
              state_d = S_RD_ACK;
          end
        end
        S_RD_ACK: begin
          if (scl_fall)
            sda_oe_d = 1'b0;
          if (scl_rise) begin
            cnt_d = 3'd0;
            if (!sda_s) begin
              state_d = S_RD_DATA;
              tx_d    = rd_byte;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_IGNORE: sda_oe_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      scl_q       <= 3'b111;
      sda_q       <= 3'b111;
      cnt_q       <= 3'd0;
      shift_q     <= 7'd0;
      tx_q        <= 8'd0;
      sda_oe_q    <= 1'b0;
      sel_q       <= 3'd0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      sda_oe_q    <= sda_oe_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_sel_target.sv
// Self-checking bench for i2c_sel_target: bus-level master tasks plus a
// transaction-level model of the expected select value and ACK pattern.
module tb_i2c_sel_target;

  localparam int Q = 50;

  logic       clk;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [2:0] sel;
  logic       sel_valid;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int sv_cnt = 0;
  int oe_cnt = 0;
  logic [2:0] sel_m = 3'd0;

  i2c_sel_target #(.ADDR(7'h70)) dut (
    .clk(clk),
    .rst(rst),
    .scl_in(scl_in),
    .sda_in(sda_in),
    .sda_oe(sda_oe),
    .sel(sel),
    .sel_valid(sel_valid),
    .busy(busy)
  );

  // open-drain bus: either side can pull low
  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sel_valid) sv_cnt++;
    if (sda_oe) oe_cnt++;
  end

  task automatic bus_start();
    if (scl_m == 1'b0) begin
      sda_m = 1'b1;
      #Q;
      scl_m = 1'b1;
      #Q;
    end
    sda_m = 1'b0;
    #(2*Q);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    #Q;
    sda_m = 1'b0;
    #Q;
    scl_m = 1'b1;
    #(2*Q);
    sda_m = 1'b1;
    #(2*Q);
  endtask

  task automatic write_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      #Q;
      sda_m = d[7-i];
      #Q;
      scl_m = 1'b1;
      #(2*Q);
      scl_m = 1'b0;
    end
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    write_bits(d, 8);
    #Q;
    sda_m = 1'b1;
    #Q;
    scl_m = 1'b1;
    #Q;
    ack = ~sda_in;
    #Q;
    scl_m = 1'b0;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d,
                           output logic oe_slot);
    for (int i = 7; i >= 0; i--) begin
      #Q;
      sda_m = 1'b1;
      #Q;
      scl_m = 1'b1;
      #Q;
      d[i] = sda_in;
      #Q;
      scl_m = 1'b0;
    end
    #Q;
    sda_m = ~m_ack;
    #Q;
    scl_m = 1'b1;
    #Q;
    oe_slot = sda_oe;
    #Q;
    scl_m = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sda_oe, sel, sel_valid, busy} !== 6'b0) begin
      n_err++;
      $display("FAIL reset: got oe=%b sel=%0d sv=%b busy=%b want all 0",
               sda_oe, sel, sel_valid, busy);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_basic();
    logic a0, a1;
    int sv0;
    sv0 = sv_cnt;
    bus_start();
    #(2*Q);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL wr_busy_start: got %b want 1", busy);
    end
    write_byte(8'hE0, a0);
    write_byte(8'h05, a1);
    bus_stop();
    sel_m = 3'd5;
    n_cmp++;
    if ({a0, a1} !== 2'b11) begin
      n_err++;
      $display("FAIL wr_acks: got %b%b want 11", a0, a1);
    end
    n_cmp++;
    if (sel !== 3'd5) begin
      n_err++;
      $display("FAIL wr_sel: got %0d want 5", sel);
    end
    n_cmp++;
    if (sv_cnt - sv0 != 1) begin
      n_err++;
      $display("FAIL wr_sel_valid_cycles: got %0d want 1", sv_cnt - sv0);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL wr_busy_stop: got %b want 0", busy);
    end
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1;
    int oe0;
    oe0 = oe_cnt;
    bus_start();
    write_byte(8'hE2, a0);
    write_byte(8'h03, a1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL nomatch_busy: got %b want 1", busy);
    end
    bus_stop();
    n_cmp++;
    if (oe_cnt != oe0 || {a0, a1} !== 2'b00) begin
      n_err++;
      $display("FAIL nomatch_oe: got oe_cycles=%0d acks=%b%b want 0 00",
               oe_cnt - oe0, a0, a1);
    end
    n_cmp++;
    if (sel !== sel_m || busy !== 1'b0) begin
      n_err++;
      $display("FAIL nomatch_sel: got sel=%0d busy=%b want %0d 0",
               sel, busy, sel_m);
    end
  endtask

  task automatic test_data_nack();
    logic a0, a1;
    int sv0;
    sv0 = sv_cnt;
    bus_start();
    write_byte(8'hE0, a0);
    write_byte(8'h0B, a1);
    bus_stop();
    n_cmp++;
    if ({a0, a1} !== 2'b10) begin
      n_err++;
      $display("FAIL nack_acks: got %b%b want 10", a0, a1);
    end
    n_cmp++;
    if (sel !== sel_m || sv_cnt != sv0) begin
      n_err++;
      $display("FAIL nack_sel: got sel=%0d pulses=%0d want %0d 0",
               sel, sv_cnt - sv0, sel_m);
    end
  endtask

  task automatic test_read();
    logic a0, a1, oe_slot;
    logic [7:0] d;
    bus_start();
    write_byte(8'hE0, a0);
    write_byte(8'h03, a1);
    bus_stop();
    sel_m = 3'd3;
    bus_start();
    write_byte(8'hE1, a0);
    read_byte(1'b0, d, oe_slot);
    bus_stop();
    n_cmp++;
    if (a0 !== 1'b1 || d !== 8'h03) begin
      n_err++;
      $display("FAIL read_data: got ack=%b data=%h want 1 03", a0, d);
    end
    n_cmp++;
    if (oe_slot !== 1'b0) begin
      n_err++;
      $display("FAIL read_ack_slot_oe: got %b want 0", oe_slot);
    end
    n_cmp++;
    if (busy !== 1'b0 || sda_oe !== 1'b0) begin
      n_err++;
      $display("FAIL read_idle: got busy=%b oe=%b want 0 0", busy, sda_oe);
    end
  endtask

  task automatic test_restart();
    logic a0, a1, a2;
    int sv0;
    sv0 = sv_cnt;
    bus_start();
    write_byte(8'hE0, a0);
    write_bits(8'h06, 4);
    bus_start();
    n_cmp++;
    if (sel !== sel_m || sv_cnt != sv0) begin
      n_err++;
      $display("FAIL restart_partial: got sel=%0d pulses=%0d want %0d 0",
               sel, sv_cnt - sv0, sel_m);
    end
    write_byte(8'hE0, a1);
    write_byte(8'h02, a2);
    bus_stop();
    sel_m = 3'd2;
    n_cmp++;
    if ({a0, a1, a2} !== 3'b111) begin
      n_err++;
      $display("FAIL restart_acks: got %b%b%b want 111", a0, a1, a2);
    end
    n_cmp++;
    if (sel !== 3'd2 || sv_cnt - sv0 != 1) begin
      n_err++;
      $display("FAIL restart_sel: got sel=%0d pulses=%0d want 2 1",
               sel, sv_cnt - sv0);
    end
  endtask

  task automatic test_rst_mid();
    logic a0, a1;
    int sv0;
    bus_start();
    write_byte(8'hE0, a0);
    write_byte(8'h05, a1);
    bus_stop();
    sel_m = 3'd5;
    bus_start();
    write_bits(8'hE0, 8);
    #Q;
    sda_m = 1'b1;
    #Q;
    scl_m = 1'b1;
    #Q;
    n_cmp++;
    if (sda_oe !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_ack_driven: got %b want 1", sda_oe);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sel_m = 3'd0;
    n_cmp++;
    if (sda_oe !== 1'b0 || sel !== 3'd0) begin
      n_err++;
      $display("FAIL rstmid_clear: got oe=%b sel=%0d want 0 0", sda_oe, sel);
    end
    #Q;
    scl_m = 1'b0;
    sv0 = sv_cnt;
    write_byte(8'h05, a1);
    write_byte(8'h01, a0);
    n_cmp++;
    if ({a0, a1} !== 2'b00 || sel !== 3'd0 || sv_cnt != sv0) begin
      n_err++;
      $display("FAIL rstmid_ignored: got acks=%b%b sel=%0d pulses=%0d want 00 0 0",
               a0, a1, sel, sv_cnt - sv0);
    end
    bus_stop();
    bus_start();
    write_byte(8'hE0, a0);
    write_byte(8'h06, a1);
    bus_stop();
    sel_m = 3'd6;
    n_cmp++;
    if ({a0, a1} !== 2'b11 || sel !== 3'd6) begin
      n_err++;
      $display("FAIL rstmid_fresh: got acks=%b%b sel=%0d want 11 6",
               a0, a1, sel);
    end
  endtask

  task automatic test_random();
    logic [6:0] addr;
    logic [7:0] d, rd;
    logic       rw, ack, alive, hit, oe_slot;
    logic [7:0] exp_rd;
    int nb, sv0, exp_sv;
    for (int t = 0; t < 24; t++) begin
      addr = 7'h70;
      if ($urandom_range(0, 3) == 0) begin
        addr = 7'($urandom_range(0, 127));
        if (addr == 7'h70) addr = 7'h0F;
      end
      rw = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      hit = (addr == 7'h70);
      sv0 = sv_cnt;
      exp_sv = 0;
      bus_start();
      write_byte({addr, rw}, ack);
      n_cmp++;
      if (ack !== hit) begin
        n_err++;
        $display("FAIL rnd_addr_ack t=%0d: got %b want %b", t, ack, hit);
      end
      alive = hit;
      for (int b = 0; b < nb; b++) begin
        if (rw) begin
          exp_rd = alive ? {5'b0, sel_m} : 8'hFF;
          read_byte(b != nb - 1, rd, oe_slot);
          n_cmp++;
          if (rd !== exp_rd) begin
            n_err++;
            $display("FAIL rnd_read t=%0d b=%0d: got %h want %h",
                     t, b, rd, exp_rd);
          end
        end else begin
          if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(8, 255));
          else d = 8'($urandom_range(0, 7));
          write_byte(d, ack);
          n_cmp++;
          if (ack !== (alive && d < 8)) begin
            n_err++;
            $display("FAIL rnd_write_ack t=%0d b=%0d d=%h: got %b want %b",
                     t, b, d, ack, alive && d < 8);
          end
          if (alive && d < 8) begin
            sel_m = d[2:0];
            exp_sv++;
          end else begin
            alive = 1'b0;
          end
        end
      end
      bus_stop();
      n_cmp++;
      if (sel !== sel_m || sv_cnt - sv0 != exp_sv || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rnd_end t=%0d: got sel=%0d pulses=%0d busy=%b want %0d %0d 0",
                 t, sel, sv_cnt - sv0, busy, sel_m, exp_sv);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    test_reset();
    test_write_basic();
    test_addr_mismatch();
    test_data_nack();
    test_read();
    test_restart();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
